// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine sequencer.
package vend_pkg;

  // Sequencer states: accept coins, dispense, change pulse, change gap.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DISP  = 2'd1,
    CHG_P = 2'd2,
    CHG_G = 2'd3
  } vend_state_t;

  // Bit positions within the money / chg buses.
  localparam int COIN_HF_BIT  = 0;
  localparam int COIN_ONE_BIT = 1;

  // Coin values in half-yen units.
  localparam int HF_VAL  = 1;
  localparam int ONE_VAL = 2;

  // Value of the coins presented in one cycle (0..3 half-yen units).
  function automatic logic [1:0] coin_value(input logic [1:0] money);
    logic [1:0] v;
    v = '0;
    if (money[COIN_HF_BIT])  v = v + 2'(HF_VAL);
    if (money[COIN_ONE_BIT]) v = v + 2'(ONE_VAL);
    return v;
  endfunction

endpackage

// File: rtl/vend_if.sv
// Coin / request / status bundle between the coin front end and vend_ctrl.
// master: drives coins and requests; slave: the sequencer.
interface vend_if #(
  parameter int CW = 4
);
  logic [1:0]    money;
  logic          sel;
  logic          cancel;
  logic [CW-1:0] credit;
  logic          dispense;
  logic [1:0]    chg;
  logic          reject;
  logic          busy;

  modport master (
    output money, sel, cancel,
    input  credit, dispense, chg, reject, busy
  );

  modport slave (
    input  money, sel, cancel,
    output credit, dispense, chg, reject, busy
  );
endinterface

// File: rtl/vend_change.sv
// Change emitter: picks the largest coin that fits the remaining credit
// (one-yen first, a single half-yen for an odd remainder) and reports how
// much that coin takes off the credit. The sequencer alternates enabling it
// (pulse cycle) and holding it off (gap cycle) to pace the coin stream.
module vend_change
  import vend_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic [CW-1:0] credit,
  input  logic          enable,
  output logic [1:0]    chg,
  output logic [1:0]    dec,
  output logic          pending
);

  // Coin selection for the next change pulse.
  always_comb begin
    chg = '0;
    dec = '0;
    if (enable) begin
      if ({1'b0, credit} >= (CW+1)'(ONE_VAL)) begin
        chg[COIN_ONE_BIT] = 1'b1;
        dec               = 2'(ONE_VAL);
      end else if (credit != '0) begin
        chg[COIN_HF_BIT] = 1'b1;
        dec              = 2'(HF_VAL);
      end
    end
  end

  // Any credit left means another pulse is owed.
  assign pending = |credit;

endmodule

// File: rtl/vend_ctrl.sv
// Vending-machine sequencer: credit accumulation, buy/dispense cycle,
// paced change return and coin rejection. All outputs are registered.
// Build option: define VEND_AUTO_EN to dispense as soon as credit reaches
// PRICE, without waiting for sel.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE       = 5,
  parameter int MAX_CREDIT  = 15,
  parameter int DISP_CYCLES = 4
) (
  input logic   clk,
  input logic   rst,
  vend_if.slave bus
);

  localparam int CW  = $clog2(MAX_CREDIT + 1);
  // Headroom so credit + 3 never wraps before the ceiling compare.
  localparam int SW  = CW + 2;
  localparam int DCW = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;

  vend_state_t   state_reg, state_next;
  logic [CW-1:0] credit_reg, credit_next;
  logic [DCW-1:0] disp_cnt_reg, disp_cnt_next;
  logic          dispense_reg, dispense_next;
  logic [1:0]    chg_reg, chg_next;
  logic          reject_reg, reject_next;
  logic          busy_reg, busy_next;

  logic [1:0]    coin_v;
  logic          coin_any;
  logic [SW-1:0] credit_sum;
  logic          coin_ok;
  logic [SW-1:0] credit_eff;
  logic [CW-1:0] chg_src;
  logic          buy_req;
  logic          idle_cancel;
  logic          idle_buy;
  logic          disp_done;
  logic          chg_fire;
  logic [1:0]    chg_coin;
  logic [1:0]    chg_dec;
  logic          chg_pending;

  // Coin value and the credit it would produce if accepted.
  assign coin_v     = coin_value(bus.money);
  assign coin_any   = (coin_v != 2'd0);
  assign credit_sum = SW'(credit_reg) + SW'(coin_v);
  assign coin_ok    = (credit_sum <= SW'(MAX_CREDIT));
  // Effective credit in IDLE: this cycle's coins included when they fit.
  assign credit_eff = coin_ok ? credit_sum : SW'(credit_reg);
  // Credit the change emitter and the exit decisions look at.
  assign chg_src    = (state_reg == IDLE) ? credit_eff[CW-1:0] : credit_reg;

`ifdef VEND_AUTO_EN
  assign buy_req = 1'b1;
`else
  assign buy_req = bus.sel;
`endif

  // Transition conditions, kept outside the FSM block so the change
  // emitter's enable does not loop back through it.
  assign idle_cancel = (state_reg == IDLE) && bus.cancel && chg_pending;
  assign idle_buy    = (state_reg == IDLE) && buy_req && (credit_eff >= SW'(PRICE));
  assign disp_done   = (state_reg == DISP) && (disp_cnt_reg == '0);
  assign chg_fire    = idle_cancel
                     || (disp_done && chg_pending)
                     || ((state_reg == CHG_G) && chg_pending);

  vend_change #(.CW(CW)) u_change (
    .credit  (chg_src),
    .enable  (chg_fire),
    .chg     (chg_coin),
    .dec     (chg_dec),
    .pending (chg_pending)
  );

  // Next-state, credit and output decode.
  always_comb begin
    state_next    = state_reg;
    credit_next   = credit_reg;
    disp_cnt_next = disp_cnt_reg;
    reject_next   = 1'b0;
    chg_next      = chg_coin;
    case (state_reg)
      IDLE: begin
        reject_next = coin_any && !coin_ok;
        credit_next = chg_src;
        if (chg_fire) begin
          state_next  = CHG_P;
          credit_next = chg_src - CW'(chg_dec);
        end else if (idle_buy) begin
          state_next    = DISP;
          credit_next   = CW'(credit_eff - SW'(PRICE));
          disp_cnt_next = DCW'(DISP_CYCLES - 1);
        end
      end
      DISP: begin
        reject_next = coin_any;
        if (disp_done) begin
          if (chg_fire) begin
            state_next  = CHG_P;
            credit_next = chg_src - CW'(chg_dec);
          end else begin
            state_next = IDLE;
          end
        end else begin
          disp_cnt_next = disp_cnt_reg - 1'b1;
        end
      end
      CHG_P: begin
        reject_next = coin_any;
        state_next  = CHG_G;
      end
      CHG_G: begin
        reject_next = coin_any;
        if (chg_fire) begin
          state_next  = CHG_P;
          credit_next = chg_src - CW'(chg_dec);
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    dispense_next = (state_next == DISP);
    busy_next     = (state_next != IDLE);
  end

  // State, credit and registered outputs; reset discards any residual credit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      credit_reg   <= '0;
      disp_cnt_reg <= '0;
      dispense_reg <= 1'b0;
      chg_reg      <= '0;
      reject_reg   <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      credit_reg   <= credit_next;
      disp_cnt_reg <= disp_cnt_next;
      dispense_reg <= dispense_next;
      chg_reg      <= chg_next;
      reject_reg   <= reject_next;
      busy_reg     <= busy_next;
    end
  end

  assign bus.credit   = credit_reg;
  assign bus.dispense = dispense_reg;
  assign bus.chg      = chg_reg;
  assign bus.reject   = reject_reg;
  assign bus.busy     = busy_reg;

endmodule
